fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter ADDR_W, 32, width of PC and all address ports.
REQ-002 Parameter RESET_VEC, 32'h30000000, PC value while fetch is disabled.
REQ-003 Parameter FETCH_BYTES, 4, sequential PC increment; legal values 4, 8, 16.
REQ-004 Parameter STALL_W, 6, width of stall vector.
REQ-005 Parameter CNT_W, 32, width of fetch counter.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 stall  input  STALL_W  pipeline stall vector from ctrl; only bit 0 (fetch stage) is used.
REQ-009 branch_flag_i  input  1  decode-stage branch taken.
REQ-010 branch_target_address_i  input  ADDR_W  branch target.
REQ-011 flush  input  1  exception flush from ctrl.
REQ-012 new_pc  input  ADDR_W  exception handler entry address.
REQ-013 pc  output  ADDR_W  current fetch address (register).
REQ-014 ce  output  1  instruction memory chip enable (register).
REQ-015 redirect_pending_o  output  1  branch target held awaiting stall release.
REQ-016 misalign_o  output  1  pc[1:0] != 0 (register, tracks pc).
REQ-017 fetch_cnt_o  output  CNT_W  count of fetch advances (register).

Function
REQ-018 ce SHALL be 0 on the edge after rst=1 and 1 on every edge with rst=0 (one-cycle lag behind reset release).
REQ-019 At any edge where ce==0: pc <= RESET_VEC, pending cleared, misalign_o <= 0.
REQ-020 At edges with ce==1, priority SHALL be: flush > live branch (stall[0]=0) > pending redirect (stall[0]=0) > sequential (stall[0]=0) > hold.
REQ-021 flush=1: pc <= new_pc irrespective of stall or branch; pending cleared.
REQ-022 stall[0]=1, flush=0, branch_flag_i=1: pc holds; pending target <= branch_target_address_i, redirect_pending_o <= 1; a later branch while still stalled overwrites the held target.
REQ-023 stall[0]=1, no flush, no branch: pc, pending state and fetch_cnt_o hold.
REQ-024 stall[0]=0, branch_flag_i=1: pc <= branch_target_address_i; pending cleared (live branch supersedes held one).
REQ-025 stall[0]=0, no branch, pending=1: pc <= held target; pending cleared in the same edge.
REQ-026 stall[0]=0, no branch, no pending: pc <= pc + FETCH_BYTES, modulo 2^ADDR_W (wrap from top of space to 0, no flag).
REQ-027 misalign_o SHALL equal (next pc)[1:0] != 0, updated on the same edge as pc; the misaligned value is still loaded into pc.
REQ-028 fetch_cnt_o SHALL increment by 1 on every edge with ce==1, flush==0, stall[0]==0; saturates at all-ones; held otherwise.
REQ-029 Pending register SHALL be cleared on the same edge pc moves for any reason other than hold.
REQ-030 No combinational path from any input to any output.

Reset
REQ-031 rst=1 at an edge: ce <= 0, fetch_cnt_o <= 0, redirect_pending_o <= 0, misalign_o <= 0; pc <= RESET_VEC on the following edge (ce==0), and also on that edge if ce was already 0.
REQ-032 rst asserted mid-stall or with pending redirect SHALL discard the redirect; no held target survives reset.

Verification
REQ-033 Hold rst 2 cycles, release, stall=0 -> ce=1 one edge after release, pc=30000000, then 30000004, 30000008; fetch_cnt_o counts 1,2.
REQ-034 stall=6'b000001, branch_flag_i=1 target 30000100 one cycle, stall held 3 more cycles -> pc holds, redirect_pending_o=1; on release pc=30000100, pending=0.
REQ-035 Pending target 30000100 held, release coinciding with branch to 30000200 -> pc=30000200, pending=0.
REQ-036 flush=1 new_pc=00000380 with stall[0]=1 and branch active -> pc=00000380, pending=0, fetch_cnt_o unchanged.
REQ-037 pc=FFFFFFFC, stall=0 -> pc=00000000; branch to 30000002 -> pc=30000002, misalign_o=1; next sequential -> 30000006, misalign_o=1.
REQ-038 CNT_W=4, run 20 unstalled cycles -> fetch_cnt_o saturates at 4'hF; FETCH_BYTES=8 -> pc steps by 8.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter: sequential fetch, branch/flush redirects, and a
// held branch target that waits out a fetch-stage stall.
module fetch_pc_unit #(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(32'h3000_0000),
    parameter int unsigned       FETCH_BYTES = 4,
    parameter int unsigned       STALL_W     = 6,
    parameter int unsigned       CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               redirect_pending_o,
    output logic               misalign_o,
    output logic [CNT_W-1:0]   fetch_cnt_o
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(FETCH_BYTES);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic              ce_q, ce_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              mis_q, mis_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic fetch_stall_c;
    logic unused_stall_c;

    // Only the fetch-stage bit of the stall vector matters here.
    assign fetch_stall_c  = stall[0];
    assign unused_stall_c = ^stall;

    always_comb begin
        ce_d   = ~rst;
        pc_d   = pc_q;
        pend_d = pend_q;
        tgt_d  = tgt_q;
        mis_d  = mis_q;
        cnt_d  = cnt_q;

        if (rst) begin
            cnt_d  = '0;
            pend_d = 1'b0;
            mis_d  = 1'b0;
            if (!ce_q) begin
                pc_d = RESET_VEC;
            end
        end else if (!ce_q) begin
            pc_d   = RESET_VEC;
            pend_d = 1'b0;
            mis_d  = 1'b0;
        end else begin
            if (flush) begin
                pc_d   = new_pc;
                pend_d = 1'b0;
            end else if (fetch_stall_c) begin
                // A branch seen during a stall is parked; a newer one replaces it.
                if (branch_flag_i) begin
                    pend_d = 1'b1;
                    tgt_d  = branch_target_address_i;
                end
            end else if (branch_flag_i) begin
                pc_d   = branch_target_address_i;
                pend_d = 1'b0;
            end else if (pend_q) begin
                pc_d   = tgt_q;
                pend_d = 1'b0;
            end else begin
                pc_d   = pc_q + PC_STEP;
            end

            mis_d = (pc_d[1:0] != 2'b00);

            if (!flush && !fetch_stall_c && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        ce_q   <= ce_d;
        pc_q   <= pc_d;
        pend_q <= pend_d;
        tgt_q  <= tgt_d;
        mis_q  <= mis_d;
        cnt_q  <= cnt_d;
    end

    assign pc                 = pc_q;
    assign ce                 = ce_q;
    assign redirect_pending_o = pend_q;
    assign misalign_o         = mis_q;
    assign fetch_cnt_o        = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized traffic against a
// rule-level reference model; a second instance covers CNT_W=4 / FETCH_BYTES=8.
module tb_fetch_pc_unit;

    localparam logic [31:0] RV = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_address_i = '0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;

    logic [31:0] pc_a, pc_b;
    logic        ce_a, ce_b, pend_a, pend_b, mis_a, mis_b;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, index 0 = default instance, 1 = CNT_W=4/FETCH_BYTES=8
    logic [31:0] m_pc[2], m_tgt[2], m_cnt[2];
    bit          m_ce[2], m_pend[2], m_mis[2];
    logic [31:0] m_step[2] = '{32'd4, 32'd8};
    logic [31:0] m_cmax[2] = '{32'hFFFF_FFFF, 32'h0000_000F};

    // Observed outputs, copied after each edge
    logic [31:0] o_pc[2], o_cnt[2];
    logic        o_ce[2], o_pend[2], o_mis[2];

    always #5 clk = ~clk;

    fetch_pc_unit dut_a (
        .clk(clk), .rst(rst), .stall(stall), .branch_flag_i(branch_flag_i),
        .branch_target_address_i(branch_target_address_i), .flush(flush), .new_pc(new_pc),
        .pc(pc_a), .ce(ce_a), .redirect_pending_o(pend_a), .misalign_o(mis_a),
        .fetch_cnt_o(cnt_a)
    );

    fetch_pc_unit #(.CNT_W(4), .FETCH_BYTES(8)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .branch_flag_i(branch_flag_i),
        .branch_target_address_i(branch_target_address_i), .flush(flush), .new_pc(new_pc),
        .pc(pc_b), .ce(ce_b), .redirect_pending_o(pend_b), .misalign_o(mis_b),
        .fetch_cnt_o(cnt_b)
    );

    // Apply the behavioural rules for one clock edge to both model instances.
    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                if (!m_ce[k]) m_pc[k] = RV;
                m_ce[k] = 0; m_cnt[k] = 0; m_pend[k] = 0; m_mis[k] = 0;
            end else if (!m_ce[k]) begin
                m_ce[k] = 1; m_pc[k] = RV; m_pend[k] = 0; m_mis[k] = 0;
            end else begin
                if (flush) begin
                    m_pc[k] = new_pc; m_pend[k] = 0;
                end else if (stall[0]) begin
                    if (branch_flag_i) begin
                        m_pend[k] = 1; m_tgt[k] = branch_target_address_i;
                    end
                end else if (branch_flag_i) begin
                    m_pc[k] = branch_target_address_i; m_pend[k] = 0;
                end else if (m_pend[k]) begin
                    m_pc[k] = m_tgt[k]; m_pend[k] = 0;
                end else begin
                    m_pc[k] = m_pc[k] + m_step[k];
                end
                m_mis[k] = (m_pc[k] % 4) != 0;
                if (!flush && !stall[0] && m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        o_pc[0] = pc_a;  o_ce[0] = ce_a;  o_pend[0] = pend_a;  o_mis[0] = mis_a;  o_cnt[0] = cnt_a;
        o_pc[1] = pc_b;  o_ce[1] = ce_b;  o_pend[1] = pend_b;  o_mis[1] = mis_b;  o_cnt[1] = {28'd0, cnt_b};
    endtask

    task automatic idle_inputs();
        stall = '0; branch_flag_i = 0; flush = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        step(); step();
        n_cmp++; if (o_ce[0] !== 1'b0) begin n_err++; $display("FAIL rst_ce: got %b want 0", o_ce[0]); end
        n_cmp++; if (o_pc[0] !== RV) begin n_err++; $display("FAIL rst_pc: got %h want %h", o_pc[0], RV); end
        n_cmp++; if (o_cnt[0] !== 32'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", o_cnt[0]); end
        n_cmp++; if (o_pend[0] !== 1'b0 || o_mis[0] !== 1'b0) begin n_err++; $display("FAIL rst_flags: got pend=%b mis=%b want 0/0", o_pend[0], o_mis[0]); end
        rst = 0;
        step();
        n_cmp++; if (o_ce[0] !== 1'b1 || o_pc[0] !== RV) begin n_err++; $display("FAIL release: got ce=%b pc=%h want 1/%h", o_ce[0], o_pc[0], RV); end
        n_cmp++; if (o_cnt[0] !== 32'd0) begin n_err++; $display("FAIL release_cnt: got %0d want 0", o_cnt[0]); end
        step();
        n_cmp++; if (o_pc[0] !== 32'h3000_0004 || o_cnt[0] !== 32'd1) begin n_err++; $display("FAIL seq1: got pc=%h cnt=%0d want 30000004/1", o_pc[0], o_cnt[0]); end
        step();
        n_cmp++; if (o_pc[0] !== 32'h3000_0008 || o_cnt[0] !== 32'd2) begin n_err++; $display("FAIL seq2: got pc=%h cnt=%0d want 30000008/2", o_pc[0], o_cnt[0]); end
    endtask

    task automatic test_stall_branch();
        logic [31:0] held_pc;
        logic [31:0] cnt_before;
        held_pc = m_pc[0];
        cnt_before = m_cnt[0];
        stall = 6'b000001; branch_flag_i = 1; branch_target_address_i = 32'h3000_0100;
        step();
        branch_flag_i = 0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (o_pc[0] !== held_pc || o_pend[0] !== 1'b1) begin n_err++; $display("FAIL stall_hold%0d: got pc=%h pend=%b want %h/1", i, o_pc[0], o_pend[0], held_pc); end
            n_cmp++; if (o_cnt[0] !== cnt_before) begin n_err++; $display("FAIL stall_cnt%0d: got %0d want %0d", i, o_cnt[0], cnt_before); end
            if (i < 3) step();
        end
        stall = 0;
        step();
        n_cmp++; if (o_pc[0] !== 32'h3000_0100 || o_pend[0] !== 1'b0) begin n_err++; $display("FAIL stall_release: got pc=%h pend=%b want 30000100/0", o_pc[0], o_pend[0]); end
        stall = 6'b000001; branch_flag_i = 1; branch_target_address_i = 32'h3000_0400;
        step();
        branch_target_address_i = 32'h3000_0500;
        step();
        idle_inputs();
        step();
        n_cmp++; if (o_pc[0] !== 32'h3000_0500 || o_pend[0] !== 1'b0) begin n_err++; $display("FAIL overwrite: got pc=%h pend=%b want 30000500/0", o_pc[0], o_pend[0]); end
    endtask

    task automatic test_branch_supersede();
        stall = 6'b000001; branch_flag_i = 1; branch_target_address_i = 32'h3000_0100;
        step();
        stall = 0; branch_target_address_i = 32'h3000_0200;
        step();
        n_cmp++; if (o_pc[0] !== 32'h3000_0200 || o_pend[0] !== 1'b0) begin n_err++; $display("FAIL supersede: got pc=%h pend=%b want 30000200/0", o_pc[0], o_pend[0]); end
        idle_inputs();
        step();
        n_cmp++; if (o_pc[0] !== 32'h3000_0204) begin n_err++; $display("FAIL supersede_seq: got %h want 30000204", o_pc[0]); end
    endtask

    task automatic test_flush();
        logic [31:0] cnt_before;
        stall = 6'b000001; branch_flag_i = 1; branch_target_address_i = 32'h3000_0100;
        step();
        cnt_before = m_cnt[0];
        flush = 1; new_pc = 32'h0000_0380;
        step();
        n_cmp++; if (o_pc[0] !== 32'h0000_0380 || o_pend[0] !== 1'b0) begin n_err++; $display("FAIL flush: got pc=%h pend=%b want 00000380/0", o_pc[0], o_pend[0]); end
        n_cmp++; if (o_cnt[0] !== cnt_before) begin n_err++; $display("FAIL flush_cnt: got %0d want %0d", o_cnt[0], cnt_before); end
        idle_inputs();
        step();
        n_cmp++; if (o_pc[0] !== 32'h0000_0384) begin n_err++; $display("FAIL flush_seq: got %h want 00000384", o_pc[0]); end
    endtask

    task automatic test_wrap_misalign();
        branch_flag_i = 1; branch_target_address_i = 32'hFFFF_FFFC;
        step();
        branch_flag_i = 0;
        step();
        n_cmp++; if (o_pc[0] !== 32'h0000_0000 || o_mis[0] !== 1'b0) begin n_err++; $display("FAIL wrap: got pc=%h mis=%b want 00000000/0", o_pc[0], o_mis[0]); end
        branch_flag_i = 1; branch_target_address_i = 32'h3000_0002;
        step();
        n_cmp++; if (o_pc[0] !== 32'h3000_0002 || o_mis[0] !== 1'b1) begin n_err++; $display("FAIL misalign: got pc=%h mis=%b want 30000002/1", o_pc[0], o_mis[0]); end
        branch_flag_i = 0;
        step();
        n_cmp++; if (o_pc[0] !== 32'h3000_0006 || o_mis[0] !== 1'b1) begin n_err++; $display("FAIL misalign_seq: got pc=%h mis=%b want 30000006/1", o_pc[0], o_mis[0]); end
    endtask

    task automatic test_reset_discard();
        stall = 6'b000001; branch_flag_i = 1; branch_target_address_i = 32'h3000_0700;
        step();
        rst = 1; branch_flag_i = 0;
        step();
        n_cmp++; if (o_ce[0] !== 1'b0 || o_pend[0] !== 1'b0 || o_cnt[0] !== 32'd0) begin n_err++; $display("FAIL rst_mid: got ce=%b pend=%b cnt=%0d want 0/0/0", o_ce[0], o_pend[0], o_cnt[0]); end
        rst = 0;
        step();
        stall = 0;
        step();
        n_cmp++; if (o_pc[0] !== 32'h3000_0004 || o_pend[0] !== 1'b0) begin n_err++; $display("FAIL rst_discard: got pc=%h pend=%b want 30000004/0", o_pc[0], o_pend[0]); end
    endtask

    task automatic test_saturation();
        rst = 1; idle_inputs();
        step(); step();
        rst = 0;
        step();
        step();
        n_cmp++; if (o_pc[1] !== 32'h3000_0008) begin n_err++; $display("FAIL b_step: got %h want 30000008", o_pc[1]); end
        for (int i = 1; i < 20; i++) step();
        n_cmp++; if (o_cnt[1] !== 32'h0000_000F) begin n_err++; $display("FAIL b_sat: got %h want f", o_cnt[1]); end
        n_cmp++; if (o_pc[1] !== RV + 32'd160) begin n_err++; $display("FAIL b_pc: got %h want %h", o_pc[1], RV + 32'd160); end
        n_cmp++; if (o_cnt[0] !== 32'd20 || o_pc[0] !== RV + 32'd80) begin n_err++; $display("FAIL a_run: got pc=%h cnt=%0d want %h/20", o_pc[0], o_cnt[0], RV + 32'd80); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            stall = 6'($urandom);
            branch_flag_i = ($urandom_range(0, 3) == 0);
            branch_target_address_i = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            flush = ($urandom_range(0, 15) == 0);
            new_pc = $urandom;
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (o_pc[k] !== m_pc[k] || o_ce[k] !== m_ce[k] || o_pend[k] !== m_pend[k] ||
                    o_mis[k] !== m_mis[k] || o_cnt[k] !== m_cnt[k]) begin
                    n_err++;
                    $display("FAIL rand[%0d] dut%0d: got pc=%h ce=%b pend=%b mis=%b cnt=%h want pc=%h ce=%b pend=%b mis=%b cnt=%h",
                             c, k, o_pc[k], o_ce[k], o_pend[k], o_mis[k], o_cnt[k],
                             m_pc[k], m_ce[k], m_pend[k], m_mis[k], m_cnt[k]);
                end
            end
        end
        rst = 0; idle_inputs();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = RV; m_tgt[k] = '0; m_cnt[k] = '0;
            m_ce[k] = 0; m_pend[k] = 0; m_mis[k] = 0;
        end
        test_reset();
        test_stall_branch();
        test_branch_supersede();
        test_flush();
        test_wrap_misalign();
        test_reset_discard();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
